// File: rtl/axi_burst_writer_pkg.sv
// Shared types and AXI constants for the stream-to-DDR burst writer.
package axi_burst_writer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        AW   = 3'd1,
        W    = 3'd2,
        B    = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int          AXI_ID_WIDTH   = 4;
    localparam int          AXI_USER_WIDTH = 1;
    localparam logic [1:0]  BURST_INCR     = 2'b01;
    localparam logic [1:0]  RESP_OKAY      = 2'b00;
    localparam logic [3:0]  CACHE_DEFAULT  = 4'b0011;

    // AWLEN for the next burst: min(beats left, max burst) - 1.
    function automatic logic [7:0] beats_to_awlen(input logic [31:0] beats,
                                                  input logic [31:0] max_burst);
        logic [31:0] n;
        n = (beats < max_burst) ? beats : max_burst;
        return 8'(n - 32'd1);
    endfunction

endpackage

// File: rtl/axi_burst_writer.sv
// Stream-to-DDR write engine: splits a (base, beat count) command into INCR
// bursts on an AXI4 master write port, one burst outstanding at a time.
// Optional build macro AXI_WR_ERR_CNT_EN adds a saturating err_cnt output.
module axi_burst_writer
    import axi_burst_writer_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 16,
    parameter int LEN_WIDTH  = 24
) (
    input  logic                      ACLK,
    input  logic                      ARESETN,
    input  logic                      start,
    input  logic [ADDR_WIDTH-1:0]     base_addr,
    input  logic [LEN_WIDTH-1:0]      num_beats,
    input  logic [DATA_WIDTH-1:0]     s_data,
    input  logic                      s_valid,
    output logic                      s_ready,
    output logic                      busy,
    output logic                      done,
    output logic                      bresp_err,
`ifdef AXI_WR_ERR_CNT_EN
    output logic [15:0]               err_cnt,
`endif
    output logic [AXI_ID_WIDTH-1:0]   M_AXI_AWID,
    output logic [ADDR_WIDTH-1:0]     M_AXI_AWADDR,
    output logic [7:0]                M_AXI_AWLEN,
    output logic [2:0]                M_AXI_AWSIZE,
    output logic [1:0]                M_AXI_AWBURST,
    output logic                      M_AXI_AWLOCK,
    output logic [3:0]                M_AXI_AWCACHE,
    output logic [2:0]                M_AXI_AWPROT,
    output logic [3:0]                M_AXI_AWQOS,
    output logic [AXI_USER_WIDTH-1:0] M_AXI_AWUSER,
    output logic                      M_AXI_AWVALID,
    input  logic                      M_AXI_AWREADY,
    output logic [DATA_WIDTH-1:0]     M_AXI_WDATA,
    output logic [DATA_WIDTH/8-1:0]   M_AXI_WSTRB,
    output logic                      M_AXI_WLAST,
    output logic [AXI_USER_WIDTH-1:0] M_AXI_WUSER,
    output logic                      M_AXI_WVALID,
    input  logic                      M_AXI_WREADY,
    input  logic [AXI_ID_WIDTH-1:0]   M_AXI_BID,
    input  logic [1:0]                M_AXI_BRESP,
    input  logic [AXI_USER_WIDTH-1:0] M_AXI_BUSER,
    input  logic                      M_AXI_BVALID,
    output logic                      M_AXI_BREADY
);

    localparam int BYTES     = DATA_WIDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);

    // A burst of MAX_BURST beats starting on an aligned base must fit in 4KB.
    generate
        if (MAX_BURST < 1 || MAX_BURST > 256 || MAX_BURST * BYTES > 4096) begin : g_bad_cfg
            $error("axi_burst_writer: MAX_BURST*bytes must be 1..4096 and MAX_BURST <= 256");
        end
    endgenerate

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [LEN_WIDTH-1:0]  remaining;
    logic [7:0]            beat_cnt;
    logic                  bresp_err_q;
    logic [7:0]            awlen;
    logic [8:0]            burst_beats;
    logic                  w_fire, w_last, b_fire, last_burst;
    logic                  unused_b_sideband;

    // Burst size is derived from the live remaining count; it only changes on
    // the B handshake, so AW fields and WLAST stay stable through stalls.
    assign awlen       = beats_to_awlen(32'(remaining), 32'(MAX_BURST));
    assign burst_beats = {1'b0, awlen} + 9'd1;
    assign w_last      = (state == W) && (beat_cnt == awlen);
    assign w_fire      = (state == W) && s_valid && M_AXI_WREADY;
    assign b_fire      = (state == B) && M_AXI_BVALID;
    assign last_burst  = (remaining == LEN_WIDTH'(burst_beats));

    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = cur_addr;
    assign M_AXI_AWLEN   = awlen;
    assign M_AXI_AWSIZE  = 3'(SIZE_LOG2);
    assign M_AXI_AWBURST = BURST_INCR;
    assign M_AXI_AWLOCK  = 1'b0;
    assign M_AXI_AWCACHE = CACHE_DEFAULT;
    assign M_AXI_AWPROT  = '0;
    assign M_AXI_AWQOS   = '0;
    assign M_AXI_AWUSER  = '0;
    assign M_AXI_WDATA   = s_data;
    assign M_AXI_WSTRB   = '1;
    assign M_AXI_WLAST   = w_last;
    assign M_AXI_WUSER   = '0;
    assign bresp_err     = bresp_err_q;

    // Only one burst is ever outstanding, so the B id/user carry no information.
    assign unused_b_sideband = ^{M_AXI_BID, M_AXI_BUSER};

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state and handshake outputs; the W channel is a pure pass-through.
    always_comb begin
        state_nxt     = state;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        s_ready       = 1'b0;
        busy          = 1'b1;
        done          = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) state_nxt = (num_beats == '0) ? DONE : AW;
            end
            AW: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) state_nxt = W;
            end
            W: begin
                M_AXI_WVALID = s_valid;
                s_ready      = M_AXI_WREADY;
                if (w_fire && w_last) state_nxt = B;
            end
            B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) state_nxt = last_burst ? DONE : AW;
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address/beat bookkeeping: latch on start, count beats, advance on B.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            cur_addr    <= '0;
            remaining   <= '0;
            beat_cnt    <= '0;
            bresp_err_q <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                cur_addr    <= base_addr;
                remaining   <= num_beats;
                beat_cnt    <= '0;
                bresp_err_q <= 1'b0;
            end
            if (w_fire) beat_cnt <= w_last ? 8'd0 : beat_cnt + 8'd1;
            if (b_fire) begin
                bresp_err_q <= bresp_err_q | (M_AXI_BRESP != RESP_OKAY);
                remaining   <= remaining - LEN_WIDTH'(burst_beats);
                cur_addr    <= cur_addr + (ADDR_WIDTH'(burst_beats) << SIZE_LOG2);
            end
        end
    end

`ifdef AXI_WR_ERR_CNT_EN
    // Saturating count of non-OKAY responses since the last accepted start.
    always_ff @(posedge ACLK) begin
        if (!ARESETN)                                            err_cnt <= '0;
        else if (state == IDLE && start)                         err_cnt <= '0;
        else if (b_fire && M_AXI_BRESP != RESP_OKAY && err_cnt != 16'hFFFF)
                                                                 err_cnt <= err_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_axi_burst_writer.sv
// Self-checking bench for axi_burst_writer: table of transactions driven
// against a randomly stalling slave, W beats checked against a scoreboard
// queue filled when each transaction's stream is generated.
module tb_axi_burst_writer;

    localparam int AWD = 32;
    localparam int DW  = 64;
    localparam int MB  = 16;
    localparam int LW  = 24;

    logic            ACLK = 1'b0;
    logic            ARESETN;
    logic            start;
    logic [AWD-1:0]  base_addr;
    logic [LW-1:0]   num_beats;
    logic [DW-1:0]   s_data;
    logic            s_valid, s_ready, busy, done, bresp_err;
`ifdef AXI_WR_ERR_CNT_EN
    logic [15:0]     err_cnt;
`endif
    logic [3:0]      M_AXI_AWID;
    logic [AWD-1:0]  M_AXI_AWADDR;
    logic [7:0]      M_AXI_AWLEN;
    logic [2:0]      M_AXI_AWSIZE;
    logic [1:0]      M_AXI_AWBURST;
    logic            M_AXI_AWLOCK;
    logic [3:0]      M_AXI_AWCACHE;
    logic [2:0]      M_AXI_AWPROT;
    logic [3:0]      M_AXI_AWQOS;
    logic [0:0]      M_AXI_AWUSER;
    logic            M_AXI_AWVALID, M_AXI_AWREADY;
    logic [DW-1:0]   M_AXI_WDATA;
    logic [DW/8-1:0] M_AXI_WSTRB;
    logic            M_AXI_WLAST;
    logic [0:0]      M_AXI_WUSER;
    logic            M_AXI_WVALID, M_AXI_WREADY;
    logic [3:0]      M_AXI_BID;
    logic [1:0]      M_AXI_BRESP;
    logic [0:0]      M_AXI_BUSER;
    logic            M_AXI_BVALID, M_AXI_BREADY;

    always #5 ACLK = ~ACLK;

    axi_burst_writer #(.ADDR_WIDTH(AWD), .DATA_WIDTH(DW), .MAX_BURST(MB), .LEN_WIDTH(LW)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .start(start), .base_addr(base_addr),
        .num_beats(num_beats), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .busy(busy), .done(done), .bresp_err(bresp_err),
`ifdef AXI_WR_ERR_CNT_EN
        .err_cnt(err_cnt),
`endif
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWUSER(M_AXI_AWUSER), .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WUSER(M_AXI_WUSER), .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BUSER(M_AXI_BUSER),
        .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
    );

    typedef struct {
        logic [31:0] base;
        int          n;
        int          aw_pct, w_pct, s_pct;
        int          err_burst;   // 1-based burst answered with SLVERR, 0 = none
        int          exp_bursts;
        bit          exp_err;
        bit          poke;        // pulse start mid-transfer (must be ignored)
    } vec_t;

    typedef struct {
        logic [31:0] addr;
        logic [63:0] data;
    } beat_t;

    vec_t  vecs[7];
    beat_t exp_q[$];

    int checks = 0;
    int passes = 0;

    // bench-side transaction state
    int          sidx, n_total, bursts_seen, beats_seen, w_beat, w_len, m_rem;
    logic [31:0] tag, m_addr, w_addr, prev_awaddr;
    logic [7:0]  prev_awlen;
    bit          aw_open, b_pend, prev_stall;
    bit          start_pend;
    logic [31:0] start_base;
    int          start_n;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [63:0] mk_data(input logic [31:0] t, input int i);
        return {t, 32'(i)};
    endfunction

    // Slave/source stimulus for the coming edge.
    task automatic drive(input vec_t v);
        M_AXI_AWREADY = ($urandom_range(99) < v.aw_pct);
        M_AXI_WREADY  = ($urandom_range(99) < v.w_pct);
        if (sidx < n_total && $urandom_range(99) < v.s_pct) begin
            s_valid = 1'b1;
            s_data  = mk_data(tag, sidx);
        end else begin
            s_valid = 1'b0;
            s_data  = {$urandom, $urandom};
        end
        if (!b_pend) begin
            M_AXI_BVALID = 1'b0;
        end else if (!M_AXI_BVALID && $urandom_range(99) < v.w_pct) begin
            M_AXI_BVALID = 1'b1;
            M_AXI_BRESP  = (v.err_burst == bursts_seen) ? 2'b10 : 2'b00;
        end
    endtask

    // Inspect the handshakes that the coming edge will complete.
    task automatic observe();
        int exp_len;
        beat_t e;
        if (prev_stall) begin
            chk("awvalid_held", M_AXI_AWVALID, 1);
            chk("aw_stable", {M_AXI_AWADDR, M_AXI_AWLEN}, {prev_awaddr, prev_awlen});
        end
        prev_stall  = M_AXI_AWVALID && !M_AXI_AWREADY;
        prev_awaddr = M_AXI_AWADDR;
        prev_awlen  = M_AXI_AWLEN;
        if (M_AXI_WVALID) chk("wvalid_after_aw", aw_open, 1);
        if ((s_valid && s_ready) || (M_AXI_WVALID && M_AXI_WREADY))
            chk("stream_vs_w", s_valid && s_ready, M_AXI_WVALID && M_AXI_WREADY);
        if (s_valid && s_ready) sidx++;
        if (M_AXI_AWVALID && M_AXI_AWREADY) begin
            bursts_seen++;
            exp_len = ((m_rem < MB) ? m_rem : MB) - 1;
            chk("awaddr", M_AXI_AWADDR, m_addr);
            chk("awlen", M_AXI_AWLEN, exp_len);
            chk("aw_fixed", {M_AXI_AWID, M_AXI_AWSIZE, M_AXI_AWBURST, M_AXI_AWLOCK, M_AXI_AWCACHE,
                             M_AXI_AWPROT, M_AXI_AWQOS, M_AXI_AWUSER, M_AXI_WSTRB, M_AXI_WUSER},
                {4'h0, 3'd3, 2'b01, 1'b0, 4'b0011, 3'd0, 4'd0, 1'b0, 8'hFF, 1'b0});
            m_addr  = m_addr + 32'((exp_len + 1) * 8);
            m_rem   = m_rem - (exp_len + 1);
            aw_open = 1'b1;
            w_addr  = M_AXI_AWADDR;
            w_len   = int'(M_AXI_AWLEN);
            w_beat  = 0;
        end else if (M_AXI_WVALID && M_AXI_WREADY) begin
            beats_seen++;
            if (exp_q.size() == 0) begin
                chk("extra_beat", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wdata", M_AXI_WDATA, e.data);
                chk("beat_addr", w_addr + 32'(w_beat * 8), e.addr);
            end
            chk("wlast", M_AXI_WLAST, w_beat == w_len);
            if (w_beat == w_len) begin
                aw_open = 1'b0;
                b_pend  = 1'b1;
            end
            w_beat++;
        end
        if (M_AXI_BVALID && M_AXI_BREADY) b_pend = 1'b0;
    endtask

    task automatic step(input vec_t v);
        @(negedge ACLK);
        start = start_pend;
        if (start_pend) begin
            base_addr = start_base;
            num_beats = LW'(start_n);
        end
        start_pend = 1'b0;
        drive(v);
        #1;
        observe();
    endtask

    task automatic clear_bench();
        exp_q.delete();
        sidx = 0; n_total = 0; bursts_seen = 0; beats_seen = 0;
        aw_open = 0; b_pend = 0; prev_stall = 0; w_beat = 0; w_len = 0;
        M_AXI_BVALID = 1'b0;
    endtask

    // Run one transaction; abort_beats > 0 returns early after that many W beats.
    task automatic run_txn(input vec_t v, input int abort_beats);
        bit seen_done;
        int cyc;
        clear_bench();
        tag     = $urandom;
        n_total = v.n;
        m_addr  = v.base;
        m_rem   = v.n;
        for (int i = 0; i < v.n; i++) exp_q.push_back('{v.base + 32'(i * 8), mk_data(tag, i)});
        start_pend = 1'b1; start_base = v.base; start_n = v.n;
        step(v);
        seen_done = 0;
        for (cyc = 1; cyc < 3000; cyc++) begin
            if (v.poke && cyc == 3) begin
                start_pend = 1'b1; start_base = 32'h0000_8000; start_n = 5;
            end
            step(v);
            if (cyc == 1) begin
                chk("busy_after_start", busy, v.n != 0);
                chk("bresp_err_cleared", bresp_err, 0);
            end
            if (abort_beats > 0 && beats_seen >= abort_beats) return;
            if (done) begin
                seen_done = 1;
                break;
            end
        end
        if (!seen_done) begin
            chk("done_timeout", 0, 1);
            return;
        end
        chk("burst_count", bursts_seen, v.exp_bursts);
        chk("beats_left", exp_q.size(), 0);
        chk("bresp_err", bresp_err, v.exp_err);
        chk("busy_at_done", busy, 0);
        if (v.n == 0) chk("zero_done_latency", cyc <= 2, 1);
`ifdef AXI_WR_ERR_CNT_EN
        chk("err_cnt", err_cnt, v.exp_err ? 16'd1 : 16'd0);
`endif
        step(v);
        chk("done_one_cycle", done, 0);
        chk("busy_after_done", busy, 0);
    endtask

    initial begin
        vecs[0] = '{32'h0000_1000, 16, 100, 100, 100, 0, 1, 0, 0};
        vecs[1] = '{32'h0000_0000, 37, 100, 100, 100, 0, 3, 0, 0};
        vecs[2] = '{32'h0000_0000,  0, 100, 100, 100, 0, 0, 0, 0};
        vecs[3] = '{32'h0000_2000, 40,  50,  50,  50, 0, 3, 0, 1};
        vecs[4] = '{32'h0000_3000, 37, 100, 100, 100, 2, 3, 1, 0};
        vecs[5] = '{32'h0000_4000,  1,  70,  60,  80, 0, 1, 0, 0};
        vecs[6] = '{32'h0000_5000, 32,  60,  70,  50, 0, 2, 0, 0};

        ARESETN = 1'b0; start = 1'b0; base_addr = '0; num_beats = '0;
        s_valid = 1'b0; s_data = '0; start_pend = 1'b0; start_base = '0; start_n = 0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BVALID = 1'b0;
        M_AXI_BRESP = 2'b00; M_AXI_BID = '0; M_AXI_BUSER = '0;
        clear_bench();
        repeat (3) @(negedge ACLK);
        #1;
        chk("reset_outputs",
            {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_WLAST, M_AXI_BREADY, s_ready, busy, done, bresp_err}, 8'h00);
        @(negedge ACLK);
        ARESETN = 1'b1;

        for (int t = 0; t < 7; t++) run_txn(vecs[t], 0);

        // Reset in the middle of the first burst's data phase.
        run_txn(vecs[3], 5);
        ARESETN = 1'b0;
        s_valid = 1'b1; M_AXI_WREADY = 1'b1; M_AXI_AWREADY = 1'b1;
        @(posedge ACLK);
        #1;
        chk("rst_mid_awvalid", M_AXI_AWVALID, 0);
        chk("rst_mid_wvalid", M_AXI_WVALID, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", {s_ready, M_AXI_BREADY, bresp_err}, 3'b000);
        @(negedge ACLK);
        ARESETN = 1'b1;
        s_valid = 1'b0;
        run_txn(vecs[1], 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
